// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg: shared FSM encodings and owner constants for the        |
// | memory bus arbiter.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_DONE   = 2'b11
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int WAIT_CYCLES_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/arb_wait_cnt.sv
// +----------------------------------------------------------------------+
// | arb_wait_cnt: 4-bit loadable down-counter with zero flag that times  |
// | the memory strobe.                                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_wait_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_bus_arbiter: CPU/debug arbiter and sequencer for the external    |
// | memory port. MEM_ARB_RR_EN selects round-robin, else CPU priority.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr
);

  // Out-of-range parameter values are clamped so the 4-bit counter can't wrap
  localparam int         C_WAIT_EFF  = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX :
                                       ((WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES);
  localparam logic [3:0] C_WAIT_LOAD = 4'(C_WAIT_EFF - 1);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_we;
  logic       w_any_req;
  logic       w_pick;
  logic       w_pick_we;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_cnt_zero;

  assign w_any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  logic r_last_owner;

  always_comb begin
    w_pick = OWN_CPU;
    if (cpu_req && dbg_req) begin
      w_pick = ~r_last_owner;
    end else if (dbg_req) begin
      w_pick = OWN_DBG;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_owner <= OWN_DBG;
    end else if ((r_state == ARB_IDLE) && w_any_req) begin
      r_last_owner <= w_pick;
    end
  end
`else
  always_comb begin
    w_pick = OWN_CPU;
    if (!cpu_req && dbg_req) begin
      w_pick = OWN_DBG;
    end
  end
`endif

  assign w_pick_we  = (w_pick == OWN_DBG) ? dbg_we : cpu_we;
  assign w_cnt_load = (r_state == ARB_IDLE) && w_any_req;
  assign w_cnt_dec  = (r_state == ARB_ACCESS) && !w_cnt_zero;

  arb_wait_cnt u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (C_WAIT_LOAD),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_CPU;
      r_we      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      cpu_gnt   <= 1'b0;
      dbg_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_pick;
            r_we      <= w_pick_we;
            mem_addr  <= (w_pick == OWN_DBG) ? dbg_addr  : cpu_addr;
            mem_wdata <= (w_pick == OWN_DBG) ? dbg_wdata : cpu_wdata;
            mem_rd    <= !w_pick_we;
            mem_wr    <= w_pick_we;
            cpu_gnt   <= (w_pick == OWN_CPU);
            dbg_gnt   <= (w_pick == OWN_DBG);
            r_state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (w_cnt_zero) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (r_owner == OWN_CPU) begin
              cpu_done <= 1'b1;
              if (!r_we) cpu_rdata <= mem_rdata;
            end else begin
              dbg_done <= 1'b1;
              if (!r_we) dbg_rdata <= mem_rdata;
            end
            r_state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          cpu_gnt <= 1'b0;
          dbg_gnt <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: begin
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          cpu_gnt <= 1'b0;
          dbg_gnt <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_bus_arbiter: directed bench, three arbiters (WAIT_CYCLES 1,   |
// | 3, 4) share one stimulus set; each test checks one instance.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic        cpu_gnt_o [3];
  logic        cpu_done_o[3];
  logic [15:0] cpu_rdata_o[3];
  logic        dbg_gnt_o [3];
  logic        dbg_done_o[3];
  logic [15:0] dbg_rdata_o[3];
  logic [15:0] mem_addr_o[3];
  logic [15:0] mem_wdata_o[3];
  logic        mem_rd_o[3];
  logic        mem_wr_o[3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_arbiter #(
      .AW          (16),
      .DW          (16),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt_o[g]),
      .cpu_done  (cpu_done_o[g]),
      .cpu_rdata (cpu_rdata_o[g]),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt_o[g]),
      .dbg_done  (dbg_done_o[g]),
      .dbg_rdata (dbg_rdata_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata),
      .mem_rd    (mem_rd_o[g]),
      .mem_wr    (mem_wr_o[g])
    );
  end

  typedef struct {
    logic        cr, cw;
    logic [15:0] ca;
    logic        dr, dw;
    logic [15:0] da, dd, md;
    logic        e_cg, e_dg, e_rd, e_wr, e_cd, e_dd;
    logic [15:0] e_addr, e_crd, e_drd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, cw, input logic [15:0] ca,
    input logic dr, dw, input logic [15:0] da, dd, md,
    input logic e_cg, e_dg, e_rd, e_wr, e_cd, e_dd,
    input logic [15:0] e_addr, e_crd, e_drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.md = md;
    v.e_cg = e_cg; v.e_dg = e_dg; v.e_rd = e_rd; v.e_wr = e_wr; v.e_cd = e_cd; v.e_dd = e_dd;
    v.e_addr = e_addr; v.e_crd = e_crd; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    step();
  endtask

  vec_t        tbl[9];
  logic [3:0]  ord;
  int          n_g;
  logic        prev_c, prev_d, saw_done;
  int          lat;

  initial begin
    reset = 1;
    clear_inputs();
    mem_rdata = 16'h0;
    step();
    step();
    chk("rst_cpu_gnt", 16'(cpu_gnt_o[0]), 16'h0);
    chk("rst_mem_rd", 16'(mem_rd_o[0]), 16'h0);
    chk("rst_mem_addr", mem_addr_o[0], 16'h0);
    chk("rst_cpu_rdata", cpu_rdata_o[0], 16'h0);
    reset = 0;
    step();

    // Cycle table for the WAIT_CYCLES=1 instance: CPU read, DBG write, DBG read
    tbl[0] = mk(1,0,16'h0010, 0,0,16'h0,16'h0,16'hBEEF, 1,0,1,0,0,0, 16'h0010,16'h0,16'h0);
    tbl[1] = mk(0,0,16'h0010, 0,0,16'h0,16'h0,16'hBEEF, 1,0,0,0,1,0, 16'h0010,16'hBEEF,16'h0);
    tbl[2] = mk(0,0,16'h0,    0,0,16'h0,16'h0,16'hBEEF, 0,0,0,0,0,0, 16'h0010,16'hBEEF,16'h0);
    tbl[3] = mk(0,0,16'h0,    1,1,16'h0030,16'h5555,16'hBEEF, 0,1,0,1,0,0, 16'h0030,16'hBEEF,16'h0);
    tbl[4] = mk(0,0,16'h0,    0,0,16'h0030,16'h5555,16'hBEEF, 0,1,0,0,0,1, 16'h0030,16'hBEEF,16'h0);
    tbl[5] = mk(0,0,16'h0,    0,0,16'h0,16'h0,16'hBEEF, 0,0,0,0,0,0, 16'h0030,16'hBEEF,16'h0);
    tbl[6] = mk(0,0,16'h0,    1,0,16'h0040,16'h0,16'hCAFE, 0,1,1,0,0,0, 16'h0040,16'hBEEF,16'h0);
    tbl[7] = mk(0,0,16'h0,    0,0,16'h0040,16'h0,16'hCAFE, 0,1,0,0,0,1, 16'h0040,16'hBEEF,16'hCAFE);
    tbl[8] = mk(0,0,16'h0,    0,0,16'h0,16'h0,16'hCAFE, 0,0,0,0,0,0, 16'h0040,16'hBEEF,16'hCAFE);

    for (int i = 0; i < 9; i++) begin
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca;
      dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dd;
      mem_rdata = tbl[i].md;
      step();
      chk($sformatf("t%0d_cpu_gnt", i), 16'(cpu_gnt_o[0]), 16'(tbl[i].e_cg));
      chk($sformatf("t%0d_dbg_gnt", i), 16'(dbg_gnt_o[0]), 16'(tbl[i].e_dg));
      chk($sformatf("t%0d_mem_rd", i), 16'(mem_rd_o[0]), 16'(tbl[i].e_rd));
      chk($sformatf("t%0d_mem_wr", i), 16'(mem_wr_o[0]), 16'(tbl[i].e_wr));
      chk($sformatf("t%0d_cpu_done", i), 16'(cpu_done_o[0]), 16'(tbl[i].e_cd));
      chk($sformatf("t%0d_dbg_done", i), 16'(dbg_done_o[0]), 16'(tbl[i].e_dd));
      chk($sformatf("t%0d_mem_addr", i), mem_addr_o[0], tbl[i].e_addr);
      chk($sformatf("t%0d_cpu_rdata", i), cpu_rdata_o[0], tbl[i].e_crd);
      chk($sformatf("t%0d_dbg_rdata", i), dbg_rdata_o[0], tbl[i].e_drd);
    end

    // Debug write, WAIT_CYCLES=3: strobe for 3 cycles, done at N+4
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'h1234;
    step();
    dbg_req = 0; dbg_addr = 16'hFFFF; dbg_wdata = 16'hFFFF;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("dw_c%0d_mem_wr", i), 16'(mem_wr_o[1]), 16'(i <= 3));
      chk($sformatf("dw_c%0d_dbg_done", i), 16'(dbg_done_o[1]), 16'(i == 4));
      chk($sformatf("dw_c%0d_dbg_gnt", i), 16'(dbg_gnt_o[1]), 16'(i <= 4));
      if (i <= 3) begin
        chk($sformatf("dw_c%0d_mem_addr", i), mem_addr_o[1], 16'h0020);
        chk($sformatf("dw_c%0d_mem_wdata", i), mem_wdata_o[1], 16'h1234);
      end
      step();
    end

    // Both requests held: record grant order on the WAIT_CYCLES=1 instance
    do_reset();
    cpu_req = 1; dbg_req = 1;
    n_g = 0; ord = 4'b0; prev_c = 0; prev_d = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (cpu_gnt_o[0] && dbg_gnt_o[0]) chk("both_gnt_high", 16'h1, 16'h0);
      if (n_g < 4 && cpu_gnt_o[0] && !prev_c) begin ord[n_g] = 1'b0; n_g++; end
      else if (n_g < 4 && dbg_gnt_o[0] && !prev_d) begin ord[n_g] = 1'b1; n_g++; end
      prev_c = cpu_gnt_o[0];
      prev_d = dbg_gnt_o[0];
    end
    cpu_req = 0; dbg_req = 0;
    chk("hold_grant_count", 16'(n_g), 16'd4);
`ifdef MEM_ARB_RR_EN
    chk("hold_order", 16'(ord), 16'b1010);
`else
    chk("hold_order", 16'(ord), 16'b0000);
`endif

    // Address changed right after grant must not reach mem_addr
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    step();
    cpu_req = 0; cpu_addr = 16'h0002;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("ac_c%0d_mem_addr", i), mem_addr_o[1], 16'h0001);
      chk($sformatf("ac_c%0d_mem_rd", i), 16'(mem_rd_o[1]), 16'h1);
      step();
    end

    // Reset during ACCESS cycle 2 of the WAIT_CYCLES=4 instance
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0050; mem_rdata = 16'h7777;
    step();
    cpu_req = 0;
    step();
    chk("mr_pre_mem_rd", 16'(mem_rd_o[2]), 16'h1);
    #2 reset = 1;
    #1;
    chk("mr_async_mem_rd", 16'(mem_rd_o[2]), 16'h0);
    chk("mr_async_cpu_gnt", 16'(cpu_gnt_o[2]), 16'h0);
    step();
    reset = 0;
    saw_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (cpu_done_o[2] || cpu_gnt_o[2]) saw_done = 1;
    end
    chk("mr_no_done_after_reset", 16'(saw_done), 16'h0);
    cpu_req = 1; cpu_addr = 16'h0060;
    step();
    cpu_req = 0;
    lat = 1;
    saw_done = 0;
    while (!saw_done && lat < 12) begin
      if (cpu_done_o[2]) saw_done = 1;
      else begin step(); lat++; end
    end
    chk("mr_new_done_seen", 16'(saw_done), 16'h1);
    chk("mr_new_done_latency", 16'(lat), 16'd5);
    chk("mr_new_rdata", cpu_rdata_o[2], 16'h7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer for the single external memory port. The CPU side (driven by the control unit's `mem_rd`/`mem_wr`/address mux) and a debug/loader port both issue single-word requests. The block grants one at a time, drives the memory strobes for a fixed latency, returns read data, and pulses completion to the owner. It sits between the core's bus interface and the external memory.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `WAIT_CYCLES`, 1, cycles the memory strobe is held per access; legal range 1..15
- `clock` in 1: the single clock
- `reset` in 1: asynchronous, active-high
- `cpu_req` in 1: CPU access request, level
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in AW: CPU address
- `cpu_wdata` in DW: CPU write data
- `cpu_gnt` out 1: CPU owns the bus
- `cpu_done` out 1: one-cycle completion pulse
- `cpu_rdata` out DW: read data, held until the next CPU read
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_done`, `dbg_rdata`: same as the CPU set, for the debug port
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data
- `mem_rd` out 1: memory read enable
- `mem_wr` out 1: memory write enable

## Operation
- FSM, Gray coded:
  - IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b11.
  - 2'b10 is unreachable and returns to IDLE.
- IDLE:
  - At a clock edge with any `req` high, pick the owner.
  - Latch owner, `we`, `addr`, `wdata` into internal registers.
  - Load the wait counter with `WAIT_CYCLES`-1, then go to ACCESS.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_rd` = !we, `mem_wr` = we, for exactly `WAIT_CYCLES` cycles.
  - Counter decrements each cycle; at 0, go to DONE.
  - On the last ACCESS edge, for a read, capture `mem_rdata` into the owner's `rdata` register.
- DONE:
  - The owner's `done` is high for one cycle; strobes are low; go to IDLE.
- `gnt` of the owner is high in ACCESS and DONE and low otherwise. The two `gnt`s are never high together.
- Requests are latched when granted. A requester may drop or change `req`/`addr` after seeing `gnt`.
- If `req` is still high at DONE, it is a new request, arbitrated in the following IDLE.
- The non-owner's `rdata` is never modified.
- Idle outputs: `mem_addr` and `mem_wdata` hold their last latched value. `mem_rd` = `mem_wr` = 0.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, counter 0, `last_owner` = DBG.
  - all `gnt`, `done`, `mem_rd`, `mem_wr` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dbg_rdata` = 0.
- Request sampled at edge N:
  - ACCESS spans cycles N+1 .. N+`WAIT_CYCLES`.
  - DONE is cycle N+`WAIT_CYCLES`+1.
  - IDLE is cycle N+`WAIT_CYCLES`+2.
- Back-to-back throughput: one access per `WAIT_CYCLES`+2 cycles. The mandatory IDLE cycle is the arbitration slot.
- Reset mid-access: strobes and `gnt` drop immediately, no `done` pulse, the access is lost.
- Requests arriving during ACCESS/DONE are not queued beyond the level `req`; they are evaluated in the next IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests, the requester that was not `last_owner` wins.
  - `last_owner` updates on each grant.
  - A single request is granted regardless of `last_owner`.
- `MEM_ARB_RR_EN` undefined: fixed priority, CPU always wins ties. The `last_owner` register is not built.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encodings (`ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE`)
  - owner constants (`OWN_CPU` = 1'b0, `OWN_DBG` = 1'b1)
  - the `WAIT_CYCLES` legal maximum
- One sub-module: `arb_wait_cnt`.
  - 4-bit loadable down-counter with a `zero` flag.
  - Inputs: `load`, `load_val`, `dec`.
- Arbitration, FSM, latches and the read-data registers stay in the top level.

## Test plan
- Single CPU read, `WAIT_CYCLES`=1, addr 16'h0010, memory returns 16'hBEEF:
  - `mem_rd` high 1 cycle, `cpu_done` pulses at N+2, `cpu_rdata` = 16'hBEEF.
  - `dbg_rdata` stays 0.
- Single debug write, `WAIT_CYCLES`=3, addr 16'h0020, data 16'h1234:
  - `mem_wr` high exactly 3 cycles with `mem_addr`=16'h0020 and `mem_wdata`=16'h1234.
  - `dbg_done` pulses at N+4.
- Both requests held high for 4 accesses:
  - With `MEM_ARB_RR_EN`: grant order CPU, DBG, CPU, DBG.
  - Without it: CPU, CPU, CPU, CPU.
- CPU changes `cpu_addr` from 16'h0001 to 16'h0002 the cycle after `cpu_gnt` rises:
  - `mem_addr` stays 16'h0001 for the whole access.
- `reset` asserted mid-ACCESS (`WAIT_CYCLES`=4, cycle 2):
  - `mem_rd`, `cpu_gnt` = 0 in the same cycle, no `cpu_done`.
  - After release, FSM is in IDLE and a new request completes normally.
